// File: rtl/module_sum_control.sv
// module_sum_control
//
// Sequential front end for the WIDTH-bit carry-lookahead adder. Operand A and
// then operand B are taken from the switch bus, one debounced push-button
// press per operand. Both operands drive the external adder, and the adder's
// WIDTH+1-bit result is registered with a valid flag for the display stage.
//
// Ports:
//   clk_pi     in   1        system clock, rising edge
//   rst_pi     in   1        asynchronous active-high reset
//   data_pi    in   WIDTH    switch bus (operand source)
//   load_pi    in   1        raw bouncing push-button
//   clear_pi   in   1        synchronous clear (already in clk_pi domain)
//   sum_pi     in   WIDTH+1  combinational adder result, carry in MSB
//   a_po       out  WIDTH    registered operand A
//   b_po       out  WIDTH    registered operand B
//   result_po  out  WIDTH+1  registered sum
//   valid_po   out  1        result_po matches current a_po/b_po
//   state_po   out  2        FSM state for LED debug
module module_sum_control #(
  parameter int WIDTH           = 8,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic             clk_pi,
  input  logic             rst_pi,
  input  logic [WIDTH-1:0] data_pi,
  input  logic             load_pi,
  input  logic             clear_pi,
  input  logic [WIDTH:0]   sum_pi,
  output logic [WIDTH-1:0] a_po,
  output logic [WIDTH-1:0] b_po,
  output logic [WIDTH:0]   result_po,
  output logic             valid_po,
  output logic [1:0]       state_po
);

  // Counter only needs to reach DEBOUNCE_CYCLES-1; the final qualifying edge
  // adopts the sample instead of incrementing.
  localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    WAIT_A = 2'b00,
    WAIT_B = 2'b01,
    CALC   = 2'b10,
    SHOW   = 2'b11
  } state_t;

  // ---------------------------------------------------------------------------
  // Input conditioning: 2-flop synchronizer, debouncer, rising-edge pulse
  // ---------------------------------------------------------------------------
  logic          sync1_reg;
  logic          sync2_reg;
  logic          deb_level_reg;
  logic          deb_prev_reg;
  logic [CW-1:0] deb_cnt_reg;
  logic          load_pulse;

  always_ff @(posedge clk_pi or posedge rst_pi) begin
    if (rst_pi) begin
      sync1_reg     <= 1'b0;
      sync2_reg     <= 1'b0;
      deb_level_reg <= 1'b0;
      deb_prev_reg  <= 1'b0;
      deb_cnt_reg   <= '0;
    end else begin
      sync1_reg    <= load_pi;
      sync2_reg    <= sync1_reg;
      deb_prev_reg <= deb_level_reg;
      if (sync2_reg != deb_level_reg) begin
        if (deb_cnt_reg == CNT_LAST) begin
          deb_level_reg <= sync2_reg;
          deb_cnt_reg   <= '0;
        end else begin
          deb_cnt_reg <= deb_cnt_reg + 1'b1;
        end
      end else begin
        deb_cnt_reg <= '0;
      end
    end
  end

  // High for exactly the cycle after the debounced level rises; release is
  // ignored because only the 0->1 transition matters.
  assign load_pulse = deb_level_reg & ~deb_prev_reg;

  // ---------------------------------------------------------------------------
  // Sequencing FSM with its datapath registers
  // ---------------------------------------------------------------------------
  state_t           state_reg, state_next;
  logic [WIDTH-1:0] a_reg, a_next;
  logic [WIDTH-1:0] b_reg, b_next;
  logic [WIDTH:0]   result_reg, result_next;
  logic             valid_reg, valid_next;

  always_ff @(posedge clk_pi or posedge rst_pi) begin
    if (rst_pi) begin
      state_reg  <= WAIT_A;
      a_reg      <= '0;
      b_reg      <= '0;
      result_reg <= '0;
      valid_reg  <= 1'b0;
    end else begin
      state_reg  <= state_next;
      a_reg      <= a_next;
      b_reg      <= b_next;
      result_reg <= result_next;
      valid_reg  <= valid_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    a_next      = a_reg;
    b_next      = b_reg;
    result_next = result_reg;
    valid_next  = valid_reg;

    if (clear_pi) begin
      // Clear takes priority; a coincident load pulse is simply dropped.
      state_next  = WAIT_A;
      a_next      = '0;
      b_next      = '0;
      result_next = '0;
      valid_next  = 1'b0;
    end else begin
      case (state_reg)
        WAIT_A: begin
          if (load_pulse) begin
            a_next     = data_pi;
            state_next = WAIT_B;
          end
        end
        WAIT_B: begin
          if (load_pulse) begin
            b_next     = data_pi;
            state_next = CALC;
          end
        end
        CALC: begin
          // Operands have been stable on the adder for a full cycle here.
          result_next = sum_pi;
          valid_next  = 1'b1;
          state_next  = SHOW;
        end
        SHOW: begin
          // A new press starts a chained operation; b keeps its old value.
          if (load_pulse) begin
            a_next     = data_pi;
            valid_next = 1'b0;
            state_next = WAIT_B;
          end
        end
        default: begin
          state_next = WAIT_A;
        end
      endcase
    end
  end

  assign a_po      = a_reg;
  assign b_po      = b_reg;
  assign result_po = result_reg;
  assign valid_po  = valid_reg;
  assign state_po  = state_reg;

endmodule

// File: tb/tb_module_sum_control.sv
module tb_module_sum_control;

  localparam int WIDTH = 8;

  logic             clk_pi;
  logic             rst_pi;
  logic [WIDTH-1:0] data_pi;
  logic             load_pi;
  logic             clear_pi;
  logic [WIDTH:0]   sum_pi;
  logic [WIDTH-1:0] a_po;
  logic [WIDTH-1:0] b_po;
  logic [WIDTH:0]   result_po;
  logic             valid_po;
  logic [1:0]       state_po;

  module_sum_control #(
    .WIDTH(WIDTH),
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .clk_pi   (clk_pi),
    .rst_pi   (rst_pi),
    .data_pi  (data_pi),
    .load_pi  (load_pi),
    .clear_pi (clear_pi),
    .sum_pi   (sum_pi),
    .a_po     (a_po),
    .b_po     (b_po),
    .result_po(result_po),
    .valid_po (valid_po),
    .state_po (state_po)
  );

  // Stand-in for the external carry-lookahead adder.
  assign sum_pi = {1'b0, a_po} + {1'b0, b_po};

  initial clk_pi = 1'b0;
  always #5 clk_pi = ~clk_pi;

  typedef struct {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH:0]   sum;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  logic valid_prev = 1'b0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every rising edge of valid_po consumes one expected result.
  always @(negedge clk_pi) begin
    if (valid_po && !valid_prev) begin
      if (exp_q.size() == 0) begin
        check_val("sb_unexpected_valid", 32'(result_po), 32'h0);
        check_val("sb_queue_empty", 32'(valid_po), 32'h0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        $display("[TB] result a=0x%02h b=0x%02h sum=0x%03h (expected 0x%03h)",
                 a_po, b_po, result_po, e.sum);
        check_val("sb_result", 32'(result_po), 32'(e.sum));
        check_val("sb_a", 32'(a_po), 32'(e.a));
        check_val("sb_b", 32'(b_po), 32'(e.b));
      end
    end
    valid_prev = valid_po;
  end

  // Raise load at a negedge; the following posedge is edge 0.
  task automatic start_press(input logic [WIDTH-1:0] d);
    @(negedge clk_pi);
    data_pi = d;
    load_pi = 1'b1;
  endtask

  // Land on the negedge following edge k (counted from start_press).
  task automatic to_edge(input int k);
    repeat (k + 1) @(negedge clk_pi);
  endtask

  // Complete a 10-cycle press started with start_press after `done` negedges,
  // then leave enough low time for the release to debounce.
  task automatic finish_press(input int done);
    repeat (10 - done) @(negedge clk_pi);
    load_pi = 1'b0;
    repeat (10) @(negedge clk_pi);
  endtask

  task automatic full_press(input logic [WIDTH-1:0] d);
    start_press(d);
    finish_press(0);
  endtask

  task automatic glitch(input int len);
    @(negedge clk_pi);
    load_pi = 1'b1;
    repeat (len) @(negedge clk_pi);
    load_pi = 1'b0;
    repeat (8) @(negedge clk_pi);
  endtask

  task automatic push_exp(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    exp_t e;
    e.a   = a;
    e.b   = b;
    e.sum = {1'b0, a} + {1'b0, b};
    exp_q.push_back(e);
  endtask

  initial begin
    rst_pi   = 1'b1;
    data_pi  = '0;
    load_pi  = 1'b0;
    clear_pi = 1'b0;
    repeat (3) @(negedge clk_pi);
    check_val("rst_state", 32'(state_po), 32'h0);
    check_val("rst_valid", 32'(valid_po), 32'h0);
    check_val("rst_result", 32'(result_po), 32'h0);
    rst_pi = 1'b0;
    repeat (2) @(negedge clk_pi);

    // Bounce rejection
    glitch(1);
    glitch(2);
    glitch(3);
    check_val("bounce_state", 32'(state_po), 32'h0);
    check_val("bounce_a", 32'(a_po), 32'h0);

    // Basic add with exact capture latency
    start_press(8'h5A);
    to_edge(5);
    check_val("lat_edge5_state", 32'(state_po), 32'h0);
    @(negedge clk_pi);
    check_val("lat_edge6_state", 32'(state_po), 32'h1);
    check_val("lat_edge6_a", 32'(a_po), 32'h5A);
    finish_press(7);

    push_exp(8'h5A, 8'hC3);
    start_press(8'hC3);
    to_edge(6);
    check_val("b_capture_state", 32'(state_po), 32'h2);
    check_val("b_capture_b", 32'(b_po), 32'hC3);
    check_val("calc_valid", 32'(valid_po), 32'h0);
    @(negedge clk_pi);
    check_val("show_state", 32'(state_po), 32'h3);
    check_val("show_result", 32'(result_po), 32'h11D);
    check_val("show_valid", 32'(valid_po), 32'h1);
    finish_press(8);
    check_val("show_hold_result", 32'(result_po), 32'h11D);

    // Chained operation from SHOW
    start_press(8'hFF);
    to_edge(6);
    check_val("chain_state", 32'(state_po), 32'h1);
    check_val("chain_a", 32'(a_po), 32'hFF);
    check_val("chain_valid", 32'(valid_po), 32'h0);
    check_val("chain_b_kept", 32'(b_po), 32'hC3);
    finish_press(7);
    push_exp(8'hFF, 8'h01);
    full_press(8'h01);
    check_val("chain_result", 32'(result_po), 32'h100);
    check_val("chain_done_state", 32'(state_po), 32'h3);

    // Clear coincident with a load pulse in WAIT_B
    full_press(8'h77);
    check_val("pre_clear_state", 32'(state_po), 32'h1);
    start_press(8'h99);
    to_edge(5);
    clear_pi = 1'b1;
    @(negedge clk_pi);
    clear_pi = 1'b0;
    check_val("clear_state", 32'(state_po), 32'h0);
    check_val("clear_a", 32'(a_po), 32'h0);
    check_val("clear_b", 32'(b_po), 32'h0);
    check_val("clear_result", 32'(result_po), 32'h0);
    check_val("clear_valid", 32'(valid_po), 32'h0);
    finish_press(7);
    check_val("clear_pulse_dropped", 32'(state_po), 32'h0);

    // Reset during CALC
    full_press(8'h12);
    start_press(8'h34);
    to_edge(6);
    check_val("calc_before_rst", 32'(state_po), 32'h2);
    rst_pi = 1'b1;
    #1;
    check_val("rst_calc_state", 32'(state_po), 32'h0);
    check_val("rst_calc_b", 32'(b_po), 32'h0);
    load_pi = 1'b0;
    repeat (2) @(negedge clk_pi);
    rst_pi = 1'b0;
    repeat (5) @(negedge clk_pi);
    check_val("rst_calc_valid", 32'(valid_po), 32'h0);
    check_val("rst_calc_result", 32'(result_po), 32'h0);

    // Asynchronous reset mid-cycle with non-zero outputs
    full_press(8'h80);
    push_exp(8'h80, 8'h80);
    full_press(8'h80);
    check_val("pre_async_result", 32'(result_po), 32'h100);
    @(posedge clk_pi);
    #2;
    rst_pi = 1'b1;
    #1;
    check_val("async_state", 32'(state_po), 32'h0);
    check_val("async_a", 32'(a_po), 32'h0);
    check_val("async_b", 32'(b_po), 32'h0);
    check_val("async_result", 32'(result_po), 32'h0);
    check_val("async_valid", 32'(valid_po), 32'h0);
    repeat (2) @(negedge clk_pi);
    rst_pi = 1'b0;
    repeat (2) @(negedge clk_pi);

    check_val("sb_leftover", 32'(exp_q.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Absolute bound on run time.
  initial begin
    #200000;
    $display("[TB] FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
